// File: rtl/stage_mem_dcache_if.sv
// Lookup, word-fill and bus-snoop signals between the memory-access stage and its data cache.
// master: the stage (drives addresses, fill data, snoop strobe); slave: the cache (returns hit/data).
interface stage_mem_dcache_if;
    logic        [31:0] raddr_i;
    logic               hit_o;
    logic        [31:0] data_o;
    logic               we_i;
    logic        [31:0] waddr_i;
    logic        [31:0] wdata_i;
    logic               mem_wr_i;
    logic        [31:0] mem_a_i;

    modport master (
        output raddr_i, we_i, waddr_i, wdata_i, mem_wr_i, mem_a_i,
        input  hit_o, data_o
    );

    modport slave (
        input  raddr_i, we_i, waddr_i, wdata_i, mem_wr_i, mem_a_i,
        output hit_o, data_o
    );
endinterface

// File: rtl/stage_mem_dcache.sv
// Direct-mapped write-through word cache beside the memory-access stage: combinational lookup,
// registered word fill, optional byte-bus snoop invalidate (enabled by macro DCACHE_SNOOP_EN).
// Ports: clk, rst (sync, active-high), bus (stage_mem_dcache_if.slave).
module stage_mem_dcache #(
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 30 - INDEX_W
) (
    input logic                  clk,
    input logic                  rst,
    stage_mem_dcache_if.slave    bus
);
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Lookup
    logic [INDEX_W-1:0] r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic               r_ok;
    logic               r_hit;

    assign r_idx = bus.raddr_i[INDEX_W+1:2];
    assign r_tag = bus.raddr_i[31:2+INDEX_W];
    // Unaligned and I/O-window addresses never hit.
    assign r_ok  = (bus.raddr_i[1:0] == 2'b00) && (bus.raddr_i[17:16] != 2'b11);
    assign r_hit = r_ok && valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    assign bus.hit_o  = r_hit;
    assign bus.data_o = r_hit ? data_q[r_idx] : 32'h0;

    // Fill
    logic [INDEX_W-1:0] w_idx;
    logic               w_en;

    assign w_idx = bus.waddr_i[INDEX_W+1:2];
    assign w_en  = bus.we_i && (bus.waddr_i[1:0] == 2'b00)
                 && (bus.waddr_i[17:16] != 2'b11);

    // Snoop
    logic [INDEX_W-1:0] s_idx;
    logic               s_inv;

`ifdef DCACHE_SNOOP_EN
    logic [TAG_W-1:0] s_tag;

    assign s_idx = bus.mem_a_i[INDEX_W+1:2];
    assign s_tag = bus.mem_a_i[31:2+INDEX_W];
    // Any byte offset within a cached word kills the whole line.
    assign s_inv = bus.mem_wr_i && (bus.mem_a_i[17:16] != 2'b11)
                 && valid_q[s_idx] && (tag_q[s_idx] == s_tag);
`else
    logic unused_snoop;

    assign s_idx        = '0;
    assign s_inv        = 1'b0;
    assign unused_snoop = ^{bus.mem_wr_i, bus.mem_a_i};
`endif

    // Invalidate is applied first so a same-index fill overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (s_inv) begin
                valid_q[s_idx] <= 1'b0;
            end
            if (w_en) begin
                valid_q[w_idx] <= 1'b1;
            end
        end
    end

    // Tag/data are not reset; a fill coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_en) begin
            tag_q[w_idx]  <= bus.waddr_i[31:2+INDEX_W];
            data_q[w_idx] <= bus.wdata_i;
        end
    end
endmodule
